// File: rtl/ex_stage_pkg.sv
// Shared EX-stage definitions: op codes, exception codes, MDU FSM encoding, sideband layout.
// Pure declarations; no logic or latency of its own.
package ex_stage_pkg;

  localparam int PASS_W_DEF = 72;

  // Sideband layout, LSB first: dst_addr, ctrl_op, mem_wr_data, mem_op, br_flag, pc
  localparam int PASS_DST_LSB   = 0;
  localparam int PASS_DST_W     = 5;
  localparam int PASS_CTRL_LSB  = 5;
  localparam int PASS_CTRL_W    = 2;
  localparam int PASS_WDAT_LSB  = 7;
  localparam int PASS_WDAT_W    = 32;
  localparam int PASS_MEMOP_LSB = 39;
  localparam int PASS_MEMOP_W   = 2;
  localparam int PASS_BR_LSB    = 41;
  localparam int PASS_BR_W      = 1;
  localparam int PASS_PC_LSB    = 42;
  localparam int PASS_PC_W      = 30;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_XOR  = 4'd3,
    OP_ADDS = 4'd4,
    OP_ADDU = 4'd5,
    OP_SUBS = 4'd6,
    OP_SUBU = 4'd7,
    OP_SHRL = 4'd8,
    OP_SHLL = 4'd9,
    OP_MULU = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } alu_op_e;

  localparam logic [2:0] EXP_NO_EXP   = 3'd0;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_ITER = 32;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// Iterative shift-add multiplier / restoring divider: start in IDLE, 32 RUN cycles, result held in DONE.
// DONE persists while i_hold is high; i_abort returns RUN or DONE to IDLE immediately.
module ex_mdu
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_hold,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_run,
  output logic        o_done,
  output logic [31:0] o_result
);

  localparam logic [4:0] LAST_ITER = 5'(MDU_ITER - 1);

  mdu_state_e  r_state;
  mdu_state_e  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [3:0]  r_op;
  // r_x: accumulator (MULU) or partial remainder (DIVU/REMU)
  // r_y: shifting multiplicand or dividend-becoming-quotient
  // r_z: shifting multiplier or divisor
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_z;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LAST_ITER) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (i_abort || !i_hold) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The remainder stays below the divisor, so the difference always fits in 32 bits;
  // a zero divisor naturally yields all-ones quotient and remainder == dividend.
  assign w_shift = {r_x, r_y[31]};
  assign w_ge    = (w_shift >= {1'b0, r_z});
  assign w_diff  = w_shift[31:0] - r_z;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= OP_NOP;
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_cnt <= '0;
      r_op  <= i_op;
      r_x   <= '0;
      r_y   <= i_a;
      r_z   <= i_b;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_op == OP_MULU) begin
        if (r_z[0]) begin
          r_x <= r_x + r_y;
        end
        r_y <= {r_y[30:0], 1'b0};
        r_z <= {1'b0, r_z[31:1]};
      end else begin
        r_x <= w_ge ? w_diff : w_shift[31:0];
        r_y <= {r_y[30:0], w_ge};
      end
    end
  end

  assign o_run    = (r_state == ST_RUN);
  assign o_done   = (r_state == ST_DONE);
  assign o_result = (r_op == OP_DIVU) ? r_y : r_x;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with signed-overflow trap, plus 34-cycle iterative MUL/DIV via ex_mdu.
// EX/MEM register loads at each edge unless stall; ex_busy holds ID/EX while an MDU op is in flight.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int PASS_W = PASS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_en_,
  input  logic [3:0]        id_alu_op,
  input  logic [31:0]       id_alu_in_0,
  input  logic [31:0]       id_alu_in_1,
  input  logic              id_gpr_we_,
  input  logic [2:0]        id_exp_code,
  input  logic [PASS_W-1:0] id_pass,
  output logic              ex_busy,
  output logic              ex_en_,
  output logic [31:0]       ex_out,
  output logic              ex_gpr_we_,
  output logic [2:0]        ex_exp_code,
  output logic [PASS_W-1:0] ex_pass
);

  logic              w_flush;
  logic              w_mdu_op;
  logic              w_mdu_run;
  logic              w_mdu_done;
  logic              w_mdu_idle;
  logic              w_start;
  logic [31:0]       w_mdu_result;
  logic [31:0]       w_sum;
  logic [31:0]       w_diff;
  logic [31:0]       w_alu_out;
  logic              w_ovf;
  logic              w_trap;

  logic              r_mdu_gpr_we_;
  logic [2:0]        r_mdu_exp;
  logic              r_en_;
  logic [31:0]       r_out;
  logic              r_gpr_we_;
  logic [2:0]        r_exp;
  logic [PASS_W-1:0] r_pass;

  assign w_flush    = flush & ~stall;
  assign w_mdu_op   = is_mdu_op(id_alu_op);
  assign w_mdu_idle = ~w_mdu_run & ~w_mdu_done;
  assign w_start    = w_mdu_idle & ~id_en_ & w_mdu_op & ~w_flush;
  assign ex_busy    = ~reset & ((w_mdu_idle & ~id_en_ & w_mdu_op) | w_mdu_run);

  ex_mdu u_mdu (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_abort  (w_flush),
    .i_hold   (stall),
    .i_op     (id_alu_op),
    .i_a      (id_alu_in_0),
    .i_b      (id_alu_in_1),
    .o_run    (w_mdu_run),
    .o_done   (w_mdu_done),
    .o_result (w_mdu_result)
  );

  always_comb begin
    w_sum     = id_alu_in_0 + id_alu_in_1;
    w_diff    = id_alu_in_0 - id_alu_in_1;
    w_alu_out = '0;
    w_ovf     = 1'b0;
    case (id_alu_op)
      OP_AND:  w_alu_out = id_alu_in_0 & id_alu_in_1;
      OP_OR:   w_alu_out = id_alu_in_0 | id_alu_in_1;
      OP_XOR:  w_alu_out = id_alu_in_0 ^ id_alu_in_1;
      OP_ADDS: begin
        w_alu_out = w_sum;
        w_ovf     = (id_alu_in_0[31] == id_alu_in_1[31]) && (w_sum[31] != id_alu_in_0[31]);
      end
      OP_ADDU: w_alu_out = w_sum;
      OP_SUBS: begin
        w_alu_out = w_diff;
        w_ovf     = (id_alu_in_0[31] != id_alu_in_1[31]) && (w_diff[31] != id_alu_in_0[31]);
      end
      OP_SUBU: w_alu_out = w_diff;
      OP_SHRL: w_alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
      OP_SHLL: w_alu_out = id_alu_in_0 << id_alu_in_1[4:0];
      default: w_alu_out = '0;
    endcase
  end

  // An exception already raised upstream takes precedence over overflow.
  assign w_trap = w_ovf & (id_exp_code == EXP_NO_EXP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdu_gpr_we_ <= 1'b1;
      r_mdu_exp     <= EXP_NO_EXP;
    end else if (w_start) begin
      r_mdu_gpr_we_ <= id_gpr_we_;
      r_mdu_exp     <= id_exp_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_en_     <= 1'b1;
      r_out     <= '0;
      r_gpr_we_ <= 1'b1;
      r_exp     <= EXP_NO_EXP;
      r_pass    <= '0;
    end else if (!stall) begin
      r_pass <= id_pass;
      if (w_mdu_done) begin
        r_en_     <= 1'b0;
        r_out     <= w_mdu_result;
        r_gpr_we_ <= r_mdu_gpr_we_;
        r_exp     <= r_mdu_exp;
      end else if (ex_busy || id_en_) begin
        r_en_     <= 1'b1;
        r_out     <= '0;
        r_gpr_we_ <= 1'b1;
        r_exp     <= EXP_NO_EXP;
      end else begin
        r_en_     <= 1'b0;
        r_out     <= w_alu_out;
        r_gpr_we_ <= w_trap ? 1'b1 : id_gpr_we_;
        r_exp     <= w_trap ? EXP_OVERFLOW : id_exp_code;
      end
    end
  end

  assign ex_en_      = r_en_;
  assign ex_out      = r_out;
  assign ex_gpr_we_  = r_gpr_we_;
  assign ex_exp_code = r_exp;
  assign ex_pass     = r_pass;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU vector table plus MDU latency, flush, stall and reset sequences.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int PW = 72;

  logic          clk = 1'b0;
  logic          reset, stall, flush, id_en_, id_gpr_we_;
  logic [3:0]    id_alu_op;
  logic [31:0]   id_alu_in_0, id_alu_in_1;
  logic [2:0]    id_exp_code;
  logic [PW-1:0] id_pass;
  logic          ex_busy, ex_en_, ex_gpr_we_;
  logic [31:0]   ex_out;
  logic [2:0]    ex_exp_code;
  logic [PW-1:0] ex_pass;

  always #5 clk = ~clk;

  ex_stage #(.PASS_W(PW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_en_(id_en_), .id_alu_op(id_alu_op), .id_alu_in_0(id_alu_in_0),
    .id_alu_in_1(id_alu_in_1), .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code),
    .id_pass(id_pass), .ex_busy(ex_busy), .ex_en_(ex_en_), .ex_out(ex_out),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_pass(ex_pass)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          en_;
    logic [31:0]   out;
    logic          we_;
    logic [2:0]    ec;
    logic [PW-1:0] pass;
  } res_t;
  res_t sb[$];

  typedef struct {
    logic        en_in;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_in;
    logic [2:0]  ec_in;
    logic        en_o;
    logic [31:0] out;
    logic        we_o;
    logic [2:0]  ec_o;
  } vec_t;
  localparam int NV = 14;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en_, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic we_, input logic [2:0] ec,
                       input logic [PW-1:0] p);
    id_en_ = en_; id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b;
    id_gpr_we_ = we_; id_exp_code = ec; id_pass = p;
  endtask

  task automatic push(input logic en_, input logic [31:0] o, input logic we_,
                      input logic [2:0] ec, input logic [PW-1:0] p);
    res_t r;
    r.en_ = en_; r.out = o; r.we_ = we_; r.ec = ec; r.pass = p;
    sb.push_back(r);
  endtask

  task automatic check_out(input string name);
    res_t r;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      r = sb.pop_front();
      chk({name, "_en"},   72'(ex_en_),      72'(r.en_));
      chk({name, "_out"},  72'(ex_out),      72'(r.out));
      chk({name, "_we"},   72'(ex_gpr_we_),  72'(r.we_));
      chk({name, "_exp"},  72'(ex_exp_code), 72'(r.ec));
      chk({name, "_pass"}, ex_pass,          r.pass);
    end
  endtask

  task automatic check_bubble(input string name);
    chk({name, "_en"},  72'(ex_en_),      72'(1));
    chk({name, "_out"}, 72'(ex_out),      72'(0));
    chk({name, "_we"},  72'(ex_gpr_we_),  72'(1));
    chk({name, "_exp"}, 72'(ex_exp_code), 72'(0));
  endtask

  // Present an MDU op, count busy cycles, bubbles and edges until the result registers.
  task automatic run_mdu(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic we_,
                         input logic [2:0] ec, input logic [PW-1:0] p);
    int  edges = 0;
    int  busy_n = 0;
    int  bub = 0;
    bit  got = 0;
    drive(1'b0, op, a, b, we_, ec, p);
    push(1'b0, res, we_, ec, p);
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if (ex_busy) busy_n++;
      tick;
      edges++;
      if (ex_en_ == 1'b0) got = 1;
      else if (ex_out == 32'd0 && ex_gpr_we_ && ex_exp_code == 3'd0) bub++;
    end
    chk({name, "_done"},    72'(got),    72'(1));
    chk({name, "_edges"},   72'(edges),  72'(34));
    chk({name, "_busy"},    72'(busy_n), 72'(33));
    chk({name, "_bubbles"}, 72'(bub),    72'(33));
    check_out(name);
    id_en_ = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] pv;

    vt[0]  = '{1'b0, 4'd1,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 3'd0, 1'b0, 32'h00F0_1234, 1'b0, 3'd0};
    vt[1]  = '{1'b0, 4'd2,  32'hF000_0000, 32'h0000_000F, 1'b0, 3'd0, 1'b0, 32'hF000_000F, 1'b0, 3'd0};
    vt[2]  = '{1'b0, 4'd3,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 3'd0, 1'b0, 32'hF0F0_0F0F, 1'b0, 3'd0};
    vt[3]  = '{1'b0, 4'd4,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 3'd0, 1'b0, 32'h8000_0000, 1'b1, 3'd3};
    vt[4]  = '{1'b0, 4'd5,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 3'd0, 1'b0, 32'h8000_0000, 1'b0, 3'd0};
    vt[5]  = '{1'b0, 4'd6,  32'h8000_0000, 32'h0000_0001, 1'b0, 3'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 3'd3};
    vt[6]  = '{1'b0, 4'd6,  32'h0000_0005, 32'h0000_0007, 1'b0, 3'd0, 1'b0, 32'hFFFF_FFFE, 1'b0, 3'd0};
    vt[7]  = '{1'b0, 4'd4,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 3'd2, 1'b0, 32'h8000_0000, 1'b0, 3'd2};
    vt[8]  = '{1'b0, 4'd8,  32'h8000_0000, 32'h0000_0024, 1'b0, 3'd0, 1'b0, 32'h0800_0000, 1'b0, 3'd0};
    vt[9]  = '{1'b0, 4'd9,  32'h0000_0001, 32'h0000_001F, 1'b0, 3'd0, 1'b0, 32'h8000_0000, 1'b0, 3'd0};
    vt[10] = '{1'b0, 4'd0,  32'h0000_0005, 32'h0000_0006, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 3'd0};
    vt[11] = '{1'b0, 4'd13, 32'h1234_5678, 32'h0000_0003, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 3'd0};
    vt[12] = '{1'b1, 4'd5,  32'h0000_0002, 32'h0000_0003, 1'b0, 3'd0, 1'b1, 32'h0000_0000, 1'b1, 3'd0};
    vt[13] = '{1'b0, 4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'd0, 1'b0, 32'hFFFF_FFFE, 1'b1, 3'd0};

    // Reset with an MDU op pending, stall and flush high: busy must still read 0.
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    drive(1'b0, OP_MULU, 32'd3, 32'd4, 1'b0, 3'd0, '1);
    tick; tick;
    #1;
    chk("rst_busy", 72'(ex_busy), 72'(0));
    check_bubble("rst");
    chk("rst_pass", ex_pass, 72'(0));
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, OP_NOP, 32'd0, 32'd0, 1'b1, 3'd0, '0);
    tick;

    for (int i = 0; i < NV; i++) begin
      pv = {8'(i), $urandom, $urandom};
      drive(vt[i].en_in, vt[i].op, vt[i].a, vt[i].b, vt[i].we_in, vt[i].ec_in, pv);
      push(vt[i].en_o, vt[i].out, vt[i].we_o, vt[i].ec_o, pv);
      #1;
      chk($sformatf("vec%0d_busy", i), 72'(ex_busy), 72'(0));
      tick;
      check_out($sformatf("vec%0d", i));
    end

    // Stall (with flush, which must be ignored) holds the EX/MEM register.
    drive(1'b0, OP_ADDU, 32'd2, 32'd3, 1'b0, 3'd0, 72'h11);
    tick;
    chk("hold_pre_out", 72'(ex_out), 72'(5));
    drive(1'b0, OP_XOR, 32'd1, 32'd3, 1'b0, 3'd0, 72'h22);
    stall = 1'b1; flush = 1'b1;
    tick; tick;
    chk("hold_out",  72'(ex_out),  72'(5));
    chk("hold_en",   72'(ex_en_),  72'(0));
    chk("hold_pass", ex_pass,      72'h11);
    stall = 1'b0; flush = 1'b0;
    tick;
    chk("hold_rel_out", 72'(ex_out), 72'(2));

    run_mdu("mulu",   OP_MULU, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 3'd0, 72'h31);
    run_mdu("divu",   OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 3'd0, 72'h32);
    run_mdu("remu",   OP_REMU, 32'd100, 32'd7, 32'd2,  1'b0, 3'd0, 72'h33);
    run_mdu("divu0",  OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 3'd5, 72'h34);
    run_mdu("remu0",  OP_REMU, 32'h1234, 32'd0, 32'h0000_1234, 1'b0, 3'd0, 72'h35);
    tick;

    // Flush at RUN cycle 10 aborts the multiply.
    drive(1'b0, OP_MULU, 32'd5, 32'd6, 1'b0, 3'd0, 72'h41);
    #1;
    chk("fl_busy_start", 72'(ex_busy), 72'(1));
    tick;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drive(1'b0, OP_ADDU, 32'd2, 32'd3, 1'b0, 3'd0, 72'h42);
    #1;
    chk("fl_busy", 72'(ex_busy), 72'(0));
    chk("fl_state", 72'(dut.u_mdu.r_state), 72'(ST_IDLE));
    check_bubble("fl_bubble");
    chk("fl_pass", ex_pass, 72'(0));
    tick;
    chk("fl_add_en",  72'(ex_en_), 72'(0));
    chk("fl_add_out", 72'(ex_out), 72'(5));
    id_en_ = 1'b1;
    tick;

    // Stall from late RUN through three DONE cycles; result appears only after release.
    drive(1'b0, OP_MULU, 32'd3, 32'd4, 1'b0, 3'd0, 72'h51);
    repeat (31) tick;
    stall = 1'b1;
    tick; tick;
    #1;
    chk("dst_state", 72'(dut.u_mdu.r_state), 72'(ST_DONE));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dst_busy%0d", k), 72'(ex_busy), 72'(0));
      chk($sformatf("dst_en%0d", k),   72'(ex_en_),  72'(1));
      chk($sformatf("dst_out%0d", k),  72'(ex_out),  72'(0));
      if (k < 2) tick;
    end
    stall = 1'b0;
    tick;
    chk("dst_res_en",  72'(ex_en_), 72'(0));
    chk("dst_res_out", 72'(ex_out), 72'(12));
    id_en_ = 1'b1;
    tick;

    // Reset pulsed mid-RUN, overriding stall and flush.
    drive(1'b0, OP_MULU, 32'd7, 32'd9, 1'b0, 3'd0, 72'h61);
    repeat (6) tick;
    chk("mr_pre_pass", ex_pass, 72'h61);
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    #1;
    chk("mr_busy_comb", 72'(ex_busy), 72'(0));
    tick;
    check_bubble("mr");
    chk("mr_pass",  ex_pass, 72'(0));
    chk("mr_state", 72'(dut.u_mdu.r_state), 72'(ST_IDLE));
    reset = 1'b0; stall = 1'b0; flush = 1'b0; id_en_ = 1'b1;
    tick;
    #1;
    chk("mr_post_busy", 72'(ex_busy), 72'(0));
    chk("mr_post_en",   72'(ex_en_),  72'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter PASS_W, default 72, SHALL give the width of the opaque sideband: pc(30), br_flag(1), mem_op(2), mem_wr_data(32), ctrl_op(2), dst_addr(5).
REQ-002 clk  in  1  the single clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  SHALL be synchronous and active-high.
REQ-004 stall  in  1  hold request from the pipeline controller, active-high.
REQ-005 flush  in  1  discard request, active-high; SHALL act only when stall=0.
REQ-006 id_en_  in  1  ID/EX valid, active-low.
REQ-007 id_alu_op  in  4  operation code.
REQ-008 id_alu_in_0  in  32  operand A.
REQ-009 id_alu_in_1  in  32  operand B.
REQ-010 id_gpr_we_  in  1  register write enable, active-low.
REQ-011 id_exp_code  in  3  incoming exception code.
REQ-012 id_pass  in  PASS_W  sideband, carried through unchanged.
REQ-013 ex_busy  out  1  combinational stall request that holds ID/EX.
REQ-014 ex_en_  out  1  EX/MEM valid, active-low.
REQ-015 ex_out  out  32  result.
REQ-016 ex_gpr_we_  out  1  write enable, active-low.
REQ-017 ex_exp_code  out  3  exception code.
REQ-018 ex_pass  out  PASS_W  registered copy of id_pass.

Function
REQ-019 Op codes SHALL be: NOP 0, AND 1, OR 2, XOR 3, ADDS 4, ADDU 5, SUBS 6, SUBU 7, SHRL 8, SHLL 9, MULU 10, DIVU 11, REMU 12; codes 13-15 SHALL behave as NOP.
REQ-020 Single-cycle ops (0-9) SHALL compute combinationally and register into ex_* at the next edge when stall=0 and flush=0.
  - SHRL/SHLL shift A by B[4:0].
  - NOP result is 0.
REQ-021 ADDS/SUBS signed overflow with id_exp_code=NO_EXP (0) SHALL produce ex_exp_code=OVERFLOW (3) and ex_gpr_we_=1; a nonzero incoming code SHALL pass unchanged.
REQ-022 MDU FSM states SHALL be IDLE, RUN and DONE.
  - IDLE->RUN when id_en_=0, op is MULU/DIVU/REMU and flush=0; operands latched, counter cleared.
  - RUN->DONE after exactly 32 iteration cycles.
  - DONE->IDLE when stall=0.
REQ-023 ex_busy SHALL be 1 in IDLE with an MDU op pending, 1 in RUN, and 0 in DONE; for an op first presented in cycle t, busy is high for t..t+32, DONE is t+33, and the result registers at the end of t+33.
REQ-024 MULU SHALL return the low 32 bits of the unsigned product via shift-add.
REQ-025 DIVU/REMU SHALL use restoring division and return the quotient or remainder; divisor 0 SHALL yield quotient 0xFFFFFFFF and remainder equal to the dividend, in the same latency.
REQ-026 While busy, the EX/MEM outputs SHALL receive a bubble each cycle: ex_en_=1, ex_gpr_we_=1, ex_out=0, ex_exp_code=0.
REQ-027 An MDU op SHALL raise no overflow; its exp_code and gpr_we_ SHALL pass through from the latched instruction.
REQ-028 stall=1 SHALL hold all ex_* registers; RUN iterations SHALL continue under stall; DONE SHALL persist until stall=0.
REQ-029 flush=1 with stall=0 SHALL abort RUN or DONE to IDLE and load the bubble values into all ex_* registers, including ex_pass=0.
REQ-030 id_en_=1 SHALL register a bubble and never start the MDU.

Reset
REQ-031 reset=1 SHALL force IDLE, counter 0, ex_en_=1, ex_gpr_we_=1, ex_out=0, ex_exp_code=0, ex_pass=0 and ex_busy=0, overriding stall and flush, including mid-RUN.

Structure
REQ-032 Op codes, exception codes, FSM state encoding, PASS_W field offsets and widths SHALL live in the shared cpu.h/isa.h definitions.
REQ-033 The iterative multiplier/divider SHALL be a sub-module ex_mdu (start, op, a, b -> done, result); the ALU, overflow logic and EX/MEM register SHALL stay in ex_stage.

Verification
REQ-034 ADDS 0x7FFFFFFF+1, id_gpr_we_=0 -> next edge ex_out=0x80000000, ex_exp_code=3, ex_gpr_we_=1, ex_busy never high.
REQ-035 MULU 0x0001_0003 x 0x0002_0005 -> ex_busy high 33 cycles, 33 bubbles, then ex_out=0x000B_000F, ex_en_=0.
REQ-036 DIVU 100/7 then REMU 100/7 back-to-back -> ex_out=14 then 2, each after 34 edges.
REQ-037 DIVU 0x1234/0 -> ex_out=0xFFFFFFFF; REMU 0x1234/0 -> ex_out=0x1234; latency unchanged.
REQ-038 MULU, then flush at RUN cycle 10 -> FSM IDLE, ex_busy=0 next cycle, bubble registered, following ADDU 2+3 gives ex_out=5.
REQ-039 stall=1 held during DONE for 3 cycles, reset pulsed mid-RUN -> ex_* unchanged under stall; after reset all outputs at their reset values and FSM IDLE.
